// File: rtl/egress_tx_arbiter.sv
// ============================================================================
//  Module      : egress_tx_arbiter
//  Description : Packet-granular arbiter that shares the PCIe TX AXI-Stream
//                among NUM_REQ TLP sources. Requester 0 (completions) has
//                priority, capped by a starvation limit. DMA requesters
//                1..NUM_REQ-1 are served round-robin. Every packet is
//                forwarded whole through one registered output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef PCIE_DATA_WIDTH
`define PCIE_DATA_WIDTH 64
`endif
`ifndef PCIE_DATA_KW
`define PCIE_DATA_KW 8
`endif
`ifndef PCIE_TUSER_W
`define PCIE_TUSER_W 4
`endif

module egress_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int CPL_BURST_MAX = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   s_req_tvalid,
  output logic [NUM_REQ-1:0]                   s_req_tready,
  input  logic [NUM_REQ*`PCIE_DATA_WIDTH-1:0]  s_req_tdata,
  input  logic [NUM_REQ*`PCIE_DATA_KW-1:0]     s_req_tkeep,
  input  logic [NUM_REQ-1:0]                   s_req_sop,
  input  logic [NUM_REQ-1:0]                   s_req_eop,
  input  logic [NUM_REQ*`PCIE_TUSER_W-1:0]     s_req_tuser,
  input  logic                                 m_axis_tx_tready,
  output logic [`PCIE_DATA_WIDTH-1:0]          m_axis_tx_tdata,
  output logic [`PCIE_DATA_KW-1:0]             m_axis_tx_tkeep,
  output logic                                 m_axis_tx_sop,
  output logic                                 m_axis_tx_eop,
  output logic                                 m_axis_tx_tvalid,
  output logic [`PCIE_TUSER_W-1:0]             m_axis_tx_tuser,
  output logic [2:0]                           grant_id,
  output logic                                 err_nosop
);

  localparam int DW = `PCIE_DATA_WIDTH;
  localparam int KW = `PCIE_DATA_KW;
  localparam int UW = `PCIE_TUSER_W;
  localparam logic [3:0] CPL_MAX   = 4'(CPL_BURST_MAX);
  localparam logic [2:0] LAST_DMA  = 3'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_q;
  logic [2:0]           gnt_q;
  logic [2:0]           rr_ptr_q;
  logic [3:0]           cpl_cnt_q;
  logic                 err_q;

  logic                 tvalid_q;
  logic [DW-1:0]        tdata_q;
  logic [KW-1:0]        tkeep_q;
  logic [UW-1:0]        tuser_q;
  logic                 sop_q;
  logic                 eop_q;

  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   dma_elig;
  logic                 dma_any;
  logic                 rr_found;
  logic [2:0]           rr_win;
  logic                 cpl_win;
  logic [2:0]           win_id_d;
  logic [3:0]           cpl_cnt_d;
  logic [2:0]           rr_ptr_d;

  logic                 sel_valid;
  logic [DW-1:0]        sel_data;
  logic [KW-1:0]        sel_keep;
  logic [UW-1:0]        sel_user;
  logic                 sel_sop;
  logic                 sel_eop;
  logic                 out_ready;
  logic                 accept;

  // Select the next winner: completions first unless the burst cap is hit
  // while a DMA requester waits; DMA requesters searched from rr_ptr with wrap.
  always_comb begin
    int cand;
    elig      = s_req_tvalid & s_req_sop;
    dma_elig  = elig & ~NUM_REQ'(1);
    dma_any   = |dma_elig;
    rr_found  = 1'b0;
    rr_win    = 3'd1;
    cand      = 1;
    for (int off = 0; off < NUM_REQ - 1; off++) begin
      cand = ((int'(rr_ptr_q) - 1 + off) % (NUM_REQ - 1)) + 1;
      if (!rr_found && dma_elig[cand[2:0]]) begin
        rr_found = 1'b1;
        rr_win   = cand[2:0];
      end
    end
    cpl_win  = elig[0] && !((cpl_cnt_q == CPL_MAX) && dma_any);
    win_id_d = cpl_win ? 3'd0 : rr_win;
    if (cpl_win) begin
      if (!dma_any)               cpl_cnt_d = 4'd0;
      else if (cpl_cnt_q == CPL_MAX) cpl_cnt_d = cpl_cnt_q;
      else                        cpl_cnt_d = cpl_cnt_q + 4'd1;
      rr_ptr_d = rr_ptr_q;
    end else begin
      cpl_cnt_d = 4'd0;
      rr_ptr_d  = (rr_win == LAST_DMA) ? 3'd1 : rr_win + 3'd1;
    end
  end

  // Route the granted requester's beat toward the output stage.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    sel_user  = '0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q == i[2:0]) begin
        sel_valid = s_req_tvalid[i];
        sel_data  = s_req_tdata[i*DW +: DW];
        sel_keep  = s_req_tkeep[i*KW +: KW];
        sel_user  = s_req_tuser[i*UW +: UW];
        sel_sop   = s_req_sop[i];
        sel_eop   = s_req_eop[i];
      end
    end
  end

  // Output stage can take a beat when empty or being drained this cycle.
  always_comb begin
    out_ready    = ~tvalid_q | m_axis_tx_tready;
    s_req_tready = (state_q == BUSY && out_ready) ? (NUM_REQ'(1) << gnt_q) : '0;
    accept       = (state_q == BUSY) && out_ready && sel_valid;
  end

  // Arbitration FSM: IDLE decides a winner, BUSY forwards until the eop beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 3'd0;
      rr_ptr_q  <= 3'd1;
      cpl_cnt_q <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      err_q <= (state_q == IDLE) && |(s_req_tvalid & ~s_req_sop);
      case (state_q)
        IDLE: begin
          if (cpl_win || rr_found) begin
            state_q   <= BUSY;
            gnt_q     <= win_id_d;
            cpl_cnt_q <= cpl_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
          end
        end
        BUSY: begin
          if (accept && sel_eop) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Registered output beat; holds while the core stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tuser_q  <= '0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
    end else if (accept) begin
      tvalid_q <= 1'b1;
      tdata_q  <= sel_data;
      tkeep_q  <= sel_keep;
      tuser_q  <= sel_user;
      sop_q    <= sel_sop;
      eop_q    <= sel_eop;
    end else if (m_axis_tx_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign m_axis_tx_tvalid = tvalid_q;
  assign m_axis_tx_tdata  = tdata_q;
  assign m_axis_tx_tkeep  = tkeep_q;
  assign m_axis_tx_tuser  = tuser_q;
  assign m_axis_tx_sop    = sop_q;
  assign m_axis_tx_eop    = eop_q;
  assign grant_id         = gnt_q;
  assign err_nosop        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_egress_tx_arbiter.sv
// ============================================================================
//  Module      : tb_egress_tx_arbiter
//  Description : Directed self-checking bench for egress_tx_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef PCIE_DATA_WIDTH
`define PCIE_DATA_WIDTH 64
`endif
`ifndef PCIE_DATA_KW
`define PCIE_DATA_KW 8
`endif
`ifndef PCIE_TUSER_W
`define PCIE_TUSER_W 4
`endif

module tb_egress_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = `PCIE_DATA_WIDTH;
  localparam int KW = `PCIE_DATA_KW;
  localparam int UW = `PCIE_TUSER_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     s_req_tvalid = '0;
  logic [NR-1:0]     s_req_tready;
  logic [NR*DW-1:0]  s_req_tdata = '0;
  logic [NR*KW-1:0]  s_req_tkeep = '0;
  logic [NR-1:0]     s_req_sop = '0;
  logic [NR-1:0]     s_req_eop = '0;
  logic [NR*UW-1:0]  s_req_tuser = '0;
  logic              m_axis_tx_tready = 1'b1;
  logic [DW-1:0]     m_axis_tx_tdata;
  logic [KW-1:0]     m_axis_tx_tkeep;
  logic              m_axis_tx_sop;
  logic              m_axis_tx_eop;
  logic              m_axis_tx_tvalid;
  logic [UW-1:0]     m_axis_tx_tuser;
  logic [2:0]        grant_id;
  logic              err_nosop;

  egress_tx_arbiter #(.NUM_REQ(NR), .CPL_BURST_MAX(4)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .s_req_tvalid     (s_req_tvalid),
    .s_req_tready     (s_req_tready),
    .s_req_tdata      (s_req_tdata),
    .s_req_tkeep      (s_req_tkeep),
    .s_req_sop        (s_req_sop),
    .s_req_eop        (s_req_eop),
    .s_req_tuser      (s_req_tuser),
    .m_axis_tx_tready (m_axis_tx_tready),
    .m_axis_tx_tdata  (m_axis_tx_tdata),
    .m_axis_tx_tkeep  (m_axis_tx_tkeep),
    .m_axis_tx_sop    (m_axis_tx_sop),
    .m_axis_tx_eop    (m_axis_tx_eop),
    .m_axis_tx_tvalid (m_axis_tx_tvalid),
    .m_axis_tx_tuser  (m_axis_tx_tuser),
    .grant_id         (grant_id),
    .err_nosop        (err_nosop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Source model state: packets remaining, length, current beat, packet number.
  int   rem [NR];
  int   plen[NR];
  int   beat[NR];
  int   pktn[NR];
  bit   nosop[NR];
  logic mready = 1'b1;

  // Per-cycle logs and accepted output beats.
  int            cyc = 0;
  logic          vlog[0:1023];
  logic [DW-1:0] dlog[0:1023];
  logic [2:0]    glog[0:1023];
  logic          elog[0:1023];
  logic [NR-1:0] rlog[0:1023];
  logic [DW-1:0] cap_d[$];
  logic          cap_s[$];
  logic          cap_e[$];
  logic [UW-1:0] cap_u[$];
  int            cap_c[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] dval(input int i, input int p, input int b);
    return {40'h0, 8'(i), 8'(p), 8'(b)};
  endfunction

  function automatic logic [7:0] cap_id(input int k);
    if (k >= cap_d.size()) return 8'hFF;
    return cap_d[k][23:16];
  endfunction

  task automatic drive_srcs();
    for (int i = 0; i < NR; i++) begin
      if (nosop[i]) begin
        s_req_tvalid[i] = 1'b1;
        s_req_sop[i]    = 1'b0;
        s_req_eop[i]    = 1'b0;
      end else begin
        s_req_tvalid[i] = rem[i] > 0;
        s_req_sop[i]    = beat[i] == 0;
        s_req_eop[i]    = beat[i] == plen[i] - 1;
      end
      s_req_tdata[i*DW +: DW] = dval(i, pktn[i], beat[i]);
      s_req_tkeep[i*KW +: KW] = '1;
      s_req_tuser[i*UW +: UW] = UW'(i + 1);
    end
    m_axis_tx_tready = mready;
  endtask

  task automatic step();
    logic [NR-1:0] acc;
    drive_srcs();
    @(negedge clk);
    vlog[cyc] = m_axis_tx_tvalid;
    dlog[cyc] = m_axis_tx_tdata;
    glog[cyc] = grant_id;
    elog[cyc] = err_nosop;
    rlog[cyc] = s_req_tready;
    if (m_axis_tx_tvalid && m_axis_tx_tready) begin
      cap_d.push_back(m_axis_tx_tdata);
      cap_s.push_back(m_axis_tx_sop);
      cap_e.push_back(m_axis_tx_eop);
      cap_u.push_back(m_axis_tx_tuser);
      cap_c.push_back(cyc);
    end
    acc = s_req_tvalid & s_req_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        beat[i]++;
        if (beat[i] == plen[i]) begin
          beat[i] = 0;
          pktn[i]++;
          rem[i]--;
        end
      end
    end
    cyc++;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0; plen[i] = 1; beat[i] = 0; pktn[i] = 0; nosop[i] = 1'b0;
    end
    cap_d.delete(); cap_s.delete(); cap_e.delete(); cap_u.delete(); cap_c.delete();
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    mready = 1'b1;
    clear_srcs();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int t0;
    logic [7:0] exp_ids[10];

    // ---- Reset state ----
    do_reset();
    chk("rst_tvalid", 64'(m_axis_tx_tvalid), 64'd0);
    chk("rst_tdata",  64'(m_axis_tx_tdata),  64'd0);
    chk("rst_sopeop", 64'({m_axis_tx_sop, m_axis_tx_eop}), 64'd0);
    chk("rst_keep_user", 64'({m_axis_tx_tkeep, m_axis_tx_tuser}), 64'd0);
    chk("rst_grant",  64'(grant_id), 64'd0);
    chk("rst_err",    64'(err_nosop), 64'd0);
    chk("rst_tready", 64'(s_req_tready), 64'd0);

    // ---- Single 3-beat packet from req 2 ----
    rem[2] = 1; plen[2] = 3;
    t0 = cyc;
    for (int k = 0; k < 7; k++) step();
    chk("sp_tready_c0", 64'(rlog[t0]), 64'd0);
    chk("sp_tready_c1", 64'(rlog[t0+1]), 64'b0100);
    chk("sp_grant_c1",  64'(glog[t0+1]), 64'd2);
    chk("sp_valid_seq", 64'({vlog[t0], vlog[t0+1], vlog[t0+2], vlog[t0+3], vlog[t0+4], vlog[t0+5]}),
        64'b001110);
    chk("sp_nbeats", 64'(cap_d.size()), 64'd3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("sp_data%0d", k), (k < cap_d.size()) ? 64'(cap_d[k]) : 64'hDEAD, 64'(dval(2, 0, k)));
    end
    if (cap_d.size() == 3) begin
      chk("sp_sop", 64'({cap_s[0], cap_s[1], cap_s[2]}), 64'b100);
      chk("sp_eop", 64'({cap_e[0], cap_e[1], cap_e[2]}), 64'b001);
      chk("sp_user", 64'(cap_u[0]), 64'd3);
    end

    // ---- Round-robin among reqs 1..3 ----
    do_reset();
    for (int i = 1; i < NR; i++) begin rem[i] = 2; plen[i] = 1; end
    for (int k = 0; k < 16; k++) step();
    chk("rr_count", 64'(cap_d.size()), 64'd6);
    for (int k = 0; k < 6; k++) chk($sformatf("rr_id%0d", k), 64'(cap_id(k)), 64'((k % 3) + 1));
    if (cap_c.size() == 6) chk("rr_spacing", 64'(cap_c[5] - cap_c[0]), 64'd10);

    // ---- Completion priority with starvation cap ----
    do_reset();
    rem[0] = 8; plen[0] = 1;
    rem[1] = 2; plen[1] = 1;
    exp_ids = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    for (int k = 0; k < 24; k++) step();
    chk("cp_count", 64'(cap_d.size()), 64'd10);
    for (int k = 0; k < 10; k++) chk($sformatf("cp_id%0d", k), 64'(cap_id(k)), 64'(exp_ids[k]));

    // ---- Backpressure during a 4-beat packet from req 1 ----
    do_reset();
    rem[1] = 1; plen[1] = 4;
    t0 = cyc;
    for (int r = 0; r < 12; r++) begin
      mready = !(r == 3 || r == 4 || r == 6);
      step();
    end
    mready = 1'b1;
    chk("bp_count", 64'(cap_d.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_data%0d", k), (k < cap_d.size()) ? 64'(cap_d[k]) : 64'hDEAD, 64'(dval(1, 0, k)));
    end
    chk("bp_hold_c3", 64'(dlog[t0+3]), 64'(dval(1, 0, 1)));
    chk("bp_hold_c4", 64'(dlog[t0+4]), 64'(dval(1, 0, 1)));
    chk("bp_hold_c6", 64'(dlog[t0+6]), 64'(dval(1, 0, 2)));
    chk("bp_valid_held", 64'({vlog[t0+3], vlog[t0+4], vlog[t0+6]}), 64'b111);
    chk("bp_tready_c3", 64'(rlog[t0+3]), 64'd0);

    // ---- err_nosop from req 3 in IDLE ----
    do_reset();
    t0 = cyc;
    nosop[3] = 1'b1;
    step();
    nosop[3] = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("ens_pulse", 64'({elog[t0], elog[t0+1], elog[t0+2]}), 64'b010);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ens_nogrant%0d", k), 64'({glog[t0+k], rlog[t0+k][3]}), 64'd0);
    end

    // ---- Reset in the middle of a 5-beat packet from req 2 ----
    do_reset();
    rem[2] = 1; plen[2] = 5;
    for (int r = 0; r < 3; r++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_srcs();
    chk("rm_outs", 64'({m_axis_tx_tvalid, m_axis_tx_sop, m_axis_tx_eop, err_nosop, grant_id}), 64'd0);
    chk("rm_tdata", 64'(m_axis_tx_tdata), 64'd0);
    chk("rm_tready", 64'(s_req_tready), 64'd0);
    for (int i = 1; i < NR; i++) begin rem[i] = 1; plen[i] = 1; end
    for (int k = 0; k < 10; k++) step();
    chk("rm_count", 64'(cap_d.size()), 64'd3);
    for (int k = 0; k < 3; k++) chk($sformatf("rm_id%0d", k), 64'(cap_id(k)), 64'(k + 1));
    if (cap_d.size() > 0) chk("rm_fresh_sop", 64'(cap_s[0]), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
